fp_decompress_stream: RTL

Streaming, parametrised successor to the fixed 16-bit leading-one decompressor. It expands LANES compressed words of CW bits per beat into IEEE-754 FP32 words. The input uses a valid/ready handshake into a 2-stage pipeline, with selectable zero-code handling and a saturating zero-code counter. It sits between the compressed-data buffer and the FP32 consumer datapath.

---
 rtl/decomp_pkg.sv | 20 ++
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_decompress_stream.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/decomp_pkg.sv
// Shared FP32 constants and helpers for the streaming decompressor.
package decomp_pkg;

    localparam int unsigned FP32_BIAS   = 127;
    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_MANT_W = 23;
    // k never exceeds 23, so 5 bits hold it.
    localparam int unsigned K_W         = 5;

    // Ceiling log2, with a minimum result of 1 so counters never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-one locator: k = leading-zero count + 1, or 0 when the input is all zero.
module fp_lzc
    import decomp_pkg::*;
#(
    parameter int unsigned W = 15
) (
    input  logic [W-1:0]   i_data,
    output logic [K_W-1:0] o_k,
    output logic           o_zero
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        o_k = '0;
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_k = K_W'(W - i);
            end
        end
    end

    assign o_zero = (i_data == '0);

endmodule

// File: rtl/fp_decompress_stream.sv
// Streaming leading-one decompressor: LANES compressed words per beat expanded to FP32.
// Two-stage pipeline with valid/ready handshake and a saturating zero-code counter.
module fp_decompress_stream
    import decomp_pkg::*;
#(
    parameter int unsigned CW    = 16,
    parameter int unsigned LANES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [LANES*CW-1:0]   i_in_data,
    input  logic                  i_zero_mode,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [LANES*32-1:0]   o_out_data,
    output logic [31:0]           o_zero_cnt,
    input  logic                  i_cnt_clr
);

    localparam int unsigned PW  = CW - 1;
    localparam int unsigned ZCW = clog2(LANES + 1);

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Stage-1 inputs per lane
    logic [LANES-1:0] w_sign;
    logic [PW-1:0]    w_p [LANES];
    logic [K_W-1:0]   w_k [LANES];
    logic [LANES-1:0] w_zero;

    // Stage-1 registers
    logic             r_s1_valid;
    logic             r_s1_zmode;
    logic [LANES-1:0] r_s1_sign;
    logic [PW-1:0]    r_s1_p [LANES];
    logic [K_W-1:0]   r_s1_k [LANES];

    // Stage-2 registers and packed next value
    logic                r_out_valid;
    logic [LANES*32-1:0] r_out_data;
    logic [LANES*32-1:0] w_s2_data;

    // Counter
    logic [ZCW-1:0] w_zero_inc;
    logic [32:0]    w_cnt_sum;
    logic [31:0]    w_zero_cnt_nxt;
    logic [31:0]    r_zero_cnt;

    assign w_s2_adv   = !r_out_valid || i_out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_accept   = i_in_valid && w_s1_adv;
    assign o_in_ready = w_s1_adv;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PW-1:0]          w_shift;
        logic [FP32_MANT_W-1:0] w_mant;
        logic [FP32_EXP_W-1:0]  w_exp;
        logic [31:0]            w_word;

        assign w_sign[l] = i_in_data[l*CW + CW - 1];
        assign w_p[l]    = i_in_data[l*CW +: PW];

        fp_lzc #(
            .W (PW)
        ) u_lzc (
            .i_data (w_p[l]),
            .o_k    (w_k[l]),
            .o_zero (w_zero[l])
        );

        // Shifting by k pushes the leading one out of the PW-bit window.
        assign w_shift = r_s1_p[l] << r_s1_k[l];
        assign w_mant  = FP32_MANT_W'(w_shift) << (FP32_MANT_W - PW);
        assign w_exp   = FP32_EXP_W'(FP32_BIAS) - FP32_EXP_W'(r_s1_k[l]);

        // k == 0 marks a zero payload; the beat's own zero_mode picks the encoding.
        assign w_word = (r_s1_k[l] == '0)
                      ? (r_s1_zmode ? {r_s1_sign[l], 31'd0}
                                    : {r_s1_sign[l], 8'd127, 23'd0})
                      : {r_s1_sign[l], w_exp, w_mant};

        assign w_s2_data[l*32 +: 32] = w_word;
    end

    // Stage 1: capture sign, payload, k and zero_mode of an accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_zmode <= 1'b0;
            r_s1_sign  <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_s1_p[l] <= '0;
                r_s1_k[l] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_zmode <= i_zero_mode;
                r_s1_sign  <= w_sign;
                for (int l = 0; l < LANES; l++) begin
                    r_s1_p[l] <= w_p[l];
                    r_s1_k[l] <= w_k[l];
                end
            end
        end
    end

    // Stage 2: register packed FP32 words; hold them while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_s2_data;
            end
        end
    end

    // Count zero-payload lanes of the beat being accepted this cycle.
    always_comb begin
        w_zero_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            w_zero_inc = w_zero_inc + ZCW'(w_zero[l]);
        end
    end

    assign w_cnt_sum = {1'b0, r_zero_cnt} + 33'(w_zero_inc);

    // Next counter value: clear wins, otherwise saturating add on accept.
    always_comb begin
        w_zero_cnt_nxt = r_zero_cnt;
        if (i_cnt_clr) begin
            w_zero_cnt_nxt = '0;
        end else if (w_accept) begin
            w_zero_cnt_nxt = w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
        end
    end

    // Zero-code counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero_cnt <= '0;
        end else begin
            r_zero_cnt <= w_zero_cnt_nxt;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_zero_cnt  = r_zero_cnt;

endmodule
